ysyx_ifu_axi_rd: RTL and testbench
==================================

Name: ysyx_ifu_axi_rd

Overview:
- Responder side of the IFU instruction-fetch bus.
- Accepts IFU read requests (araddr/arvalid/required, plus a burst hint) and converts each into one AXI4 read transaction on the SoC crossbar.
- Returns each data word to the IFU as a one-cycle rvalid pulse.
- Sits between the IFU and the instruction-side AXI master port or arbiter.

Parameters:
- DATA_W, 32, data and address width in bits.
- BURST_LEN, 2, number of beats issued when a burst is granted (arlen = BURST_LEN-1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the rising clk edge).
- ifu_araddr  in  DATA_W  IFU fetch address.
- ifu_arvalid  in  1  IFU request valid; level, held high by the IFU until it sees rvalid.
- ifu_required  in  1  IFU mid-refill indication; forwarded to the bus lock.
- ifu_burst  in  1  IFU requests a BURST_LEN-beat incrementing burst.
- ifu_rdata  out  DATA_W  returned word, registered.
- ifu_rvalid  out  1  one-cycle pulse per returned word.
- ifu_rerr  out  1  pulses together with ifu_rvalid when rresp != OKAY.
- bus_lock_o  out  1  ifu_required | (state != IDLE); tells the arbiter to keep the grant.
- axi_arvalid  out  1  AXI AR valid.
- axi_arready  in  1  AXI AR ready.
- axi_araddr  out  DATA_W  AXI AR address.
- axi_arlen  out  8  AXI AR length.
- axi_arsize  out  3  AXI AR size; constant 3'b010.
- axi_arburst  out  2  AXI AR burst type; constant INCR (2'b01).
- axi_rvalid  in  1  AXI R valid.
- axi_rready  out  1  AXI R ready.
- axi_rdata  in  DATA_W  AXI R data.
- axi_rresp  in  2  AXI R response.
- axi_rlast  in  1  AXI R last beat.

Behaviour:
- Reset values: state=IDLE, all outputs 0 (ifu_rdata=0, axi_arlen=0); axi_arsize and axi_arburst are constants.
- IDLE:
  - On ifu_arvalid, latch the address with bits [1:0] forced to 0.
  - Burst is granted only when ifu_burst=1 and address bit 2 == 0; otherwise issue a single beat.
  - Latch axi_arlen = burst ? BURST_LEN-1 : 0, set axi_arvalid=1, go to AR.
- AR:
  - Hold axi_arvalid, axi_araddr and axi_arlen stable until axi_arready.
  - On handshake, drop axi_arvalid and go to R.
  - Minimum latency is 1 cycle when arready is already high on entry.
- R:
  - axi_rready=1 in this state only.
  - On the axi_rvalid handshake, register ifu_rdata=axi_rdata and ifu_rerr=(axi_rresp!=0), then go to RESP.
- RESP:
  - ifu_rvalid=1 for exactly this cycle; axi_rready=0, so AXI is back-pressured.
  - If the captured beat had rlast=1, go to IDLE; otherwise go back to R.
- Request acceptance after RESP:
  - A new request is never accepted in the RESP cycle, because the IFU's arvalid is still high combinationally in that cycle.
  - Earliest new accept is the cycle after RESP.
- End-to-end latency, IFU arvalid to ifu_rvalid: minimum 3 cycles (IDLE->AR->R->RESP) when arready and rvalid are immediate.
- ifu_arvalid dropping mid-transaction is ignored (AXI cannot abort); the transaction completes and its data is still pulsed.
- ifu_araddr changing after acceptance is ignored; the latched copy is used.
- A burst that ends early (rlast on beat 1 of 2) ends the transaction after that beat.
- Extra beats after rlast cannot be seen, because rready is low in IDLE.
- rlast is trusted; the beat count is not cross-checked.
- Reset mid-operation: return to IDLE immediately, drop axi_arvalid/axi_rready, clear pulses. The downstream fabric must be reset in the same cycle.
- ifu_rerr does not change the state flow; the word is still delivered.

Decomposition:
- Shared package / ysyx.svh:
  - AXI burst encodings (FIXED/INCR/WRAP).
  - AXI resp encodings (OKAY/EXOKAY/SLVERR/DECERR).
  - AXI size constant for 4-byte beats.
  - State enum: IDLE, AR, R, RESP.
- No sub-module: a single FSM with registered outputs is sufficient.

Test Plan:
- Single fetch: araddr=0x3000_0004, arvalid, burst=0, arready=1, R returns 0x0000_0413 rlast=1 -> axi_araddr=0x3000_0004, arlen=0; ifu_rvalid pulse of one cycle with rdata=0x0000_0413, rerr=0; back to IDLE.
- Burst fetch: araddr=0xA000_0000, burst=1 -> arlen=1, arburst=01; beats 0x11111111 and 0x22222222 -> two separate one-cycle rvalid pulses in order; rready low during each RESP.
- Misaligned burst: araddr=0xA000_0004, burst=1 -> arlen=0 single beat; exactly one rvalid pulse.
- AR stall plus back-to-back requests: arready low for 5 cycles -> axi_arvalid/araddr stable for all 5 cycles. Keep ifu_arvalid high through RESP -> no second AR in the RESP cycle; a new AR only after a fresh IDLE accept.
- Error: rresp=2'b10 on a single fetch -> ifu_rvalid and ifu_rerr pulse together; state returns to IDLE.
- Reset mid-burst: assert rst=0 after beat 1 of 2 -> next cycle state=IDLE, all outputs 0, no further rvalid pulse; bus_lock_o follows ifu_required only.

Source files
------------

// File: rtl/ysyx_ifu_axi_rd_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_ifu_axi_rd_pkg
// Shared definitions for the IFU-to-AXI read bridge:
//   - AXI burst type encodings (FIXED / INCR / WRAP)
//   - AXI response encodings (OKAY / EXOKAY / SLVERR / DECERR)
//   - AXI size code for 4-byte beats
//   - bridge FSM state enum
//   - helper deciding whether a requested burst can be granted
// ---------------------------------------------------------------------------
package ysyx_ifu_axi_rd_pkg;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_RESP
  } state_e;

  // A burst is only granted from an even word address, so the two-beat
  // refill never straddles the aligned 8-byte pair the IFU expects.
  function automatic logic burst_grant(input logic burst_req, input logic addr_bit2);
    return burst_req & ~addr_bit2;
  endfunction

endpackage

// File: rtl/ysyx_ifu_axi_rd_if.sv
// ---------------------------------------------------------------------------
// ysyx_ifu_axi_rd_if
// AXI4 read-only channel bundle (AR + R) between the IFU bridge and the
// instruction-side crossbar port.
//   master modport : drives AR (arvalid/araddr/arlen/arsize/arburst) and
//                    rready; receives arready and the R channel.
//   slave modport  : the opposite directions (crossbar / memory model).
// ---------------------------------------------------------------------------
interface ysyx_ifu_axi_rd_if #(
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/ysyx_ifu_axi_rd.sv
// ---------------------------------------------------------------------------
// ysyx_ifu_axi_rd
// Responder for IFU instruction fetches: turns each IFU read request into one
// AXI4 read transaction and hands every returned word back to the IFU as a
// one-cycle ifu_rvalid pulse.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   ifu_araddr        fetch address (low two bits ignored)
//   ifu_arvalid       request level, held by the IFU until it sees rvalid
//   ifu_required      IFU mid-refill; forwarded into bus_lock_o
//   ifu_burst         IFU asks for a BURST_LEN-beat INCR burst
//   ifu_rdata         returned word (registered, held between pulses)
//   ifu_rvalid        one-cycle pulse per returned word
//   ifu_rerr          pulses with ifu_rvalid when rresp != OKAY
//   bus_lock_o        keep-grant request to the arbiter
//   axi               AXI AR/R channels (master side)
//
// Flow: IDLE -accept-> AR -arready-> R -rvalid-> RESP -> (rlast ? IDLE : R)
// The RESP cycle back-pressures AXI (rready low) and never accepts a new
// request, because the IFU still holds arvalid high in that cycle.
// ---------------------------------------------------------------------------
module ysyx_ifu_axi_rd
  import ysyx_ifu_axi_rd_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  input  logic              ifu_required,
  input  logic              ifu_burst,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  output logic              ifu_rerr,
  output logic              bus_lock_o,
  ysyx_ifu_axi_rd_if.master axi
);

  localparam logic [7:0]        BURST_ARLEN = 8'(BURST_LEN - 1);
  localparam logic [DATA_W-1:0] WORD_MASK   = {{(DATA_W-2){1'b1}}, 2'b00};

  state_e            state;
  logic              arvalid_q;
  logic [DATA_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic              rready_q;
  logic              last_q;      // rlast of the beat currently being pulsed

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = AXI_SIZE_4B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.rready  = rready_q;

  // Held for the whole transaction so the arbiter cannot switch masters
  // between AR and the final R beat.
  assign bus_lock_o = ifu_required | (state != ST_IDLE);

  // NOTE: all FSM state and outputs live in one clocked block using
  // non-blocking assignments, so every output is a flop and every branch
  // reads the pre-edge values; nothing here is computed combinationally
  // from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the datapath registers (address, length, data) are reset too,
      // because all visible outputs must read 0 right after reset.
      state      <= ST_IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      rready_q   <= 1'b0;
      last_q     <= 1'b0;
      ifu_rdata  <= '0;
      ifu_rvalid <= 1'b0;
      ifu_rerr   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ifu_arvalid) begin
            araddr_q  <= ifu_araddr & WORD_MASK;
            arlen_q   <= burst_grant(ifu_burst, ifu_araddr[2]) ? BURST_ARLEN : 8'd0;
            arvalid_q <= 1'b1;
            state     <= ST_AR;
          end
        end

        ST_AR: begin
          // Address/length stay frozen until the crossbar takes them.
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_R;
          end
        end

        ST_R: begin
          if (axi.rvalid) begin
            ifu_rdata  <= axi.rdata;
            ifu_rerr   <= (axi.rresp != AXI_RESP_OKAY);
            ifu_rvalid <= 1'b1;
            last_q     <= axi.rlast;
            rready_q   <= 1'b0;
            state      <= ST_RESP;
          end
        end

        ST_RESP: begin
          ifu_rvalid <= 1'b0;
          ifu_rerr   <= 1'b0;
          // rlast is trusted as-is; an early rlast simply ends the burst.
          if (last_q) begin
            state <= ST_IDLE;
          end else begin
            rready_q <= 1'b1;
            state    <= ST_R;
          end
        end

        default: begin
          state     <= ST_IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_ifu_axi_rd.sv
// ---------------------------------------------------------------------------
// tb_ysyx_ifu_axi_rd
// Directed bench for ysyx_ifu_axi_rd. Inputs are driven and outputs sampled
// on the falling clock edge; the DUT acts on the rising edge. The AXI
// responder is played by hand, cycle by cycle, with expected values written
// out directly.
// ---------------------------------------------------------------------------
module tb_ysyx_ifu_axi_rd;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] ifu_araddr;
  logic              ifu_arvalid;
  logic              ifu_required;
  logic              ifu_burst;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_rvalid;
  logic              ifu_rerr;
  logic              bus_lock_o;

  int checks = 0;
  int errors = 0;

  ysyx_ifu_axi_rd_if #(.DATA_W(DATA_W)) axi_if ();

  ysyx_ifu_axi_rd #(.DATA_W(DATA_W), .BURST_LEN(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_araddr   (ifu_araddr),
    .ifu_arvalid  (ifu_arvalid),
    .ifu_required (ifu_required),
    .ifu_burst    (ifu_burst),
    .ifu_rdata    (ifu_rdata),
    .ifu_rvalid   (ifu_rvalid),
    .ifu_rerr     (ifu_rerr),
    .bus_lock_o   (bus_lock_o),
    .axi          (axi_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full clock: across a rising edge, back to the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_beat(input logic valid, input logic [31:0] data,
                          input logic [1:0] resp, input logic last);
    axi_if.rvalid = valid;
    axi_if.rdata  = data;
    axi_if.rresp  = resp;
    axi_if.rlast  = last;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".arvalid"}, 32'(axi_if.arvalid), 32'd0);
    check({tag, ".rready"},  32'(axi_if.rready),  32'd0);
    check({tag, ".rvalid"},  32'(ifu_rvalid),     32'd0);
    check({tag, ".rerr"},    32'(ifu_rerr),       32'd0);
  endtask

  initial begin
    int pulses;

    rst          = 1'b0;
    ifu_araddr   = '0;
    ifu_arvalid  = 1'b0;
    ifu_required = 1'b0;
    ifu_burst    = 1'b0;
    axi_if.arready = 1'b0;
    set_beat(1'b0, 32'h0, 2'b00, 1'b0);

    // ---------------- reset state ----------------
    @(negedge clk);
    tick();
    check_quiet("rst");
    check("rst.rdata",  ifu_rdata,              32'h0);
    check("rst.araddr", axi_if.araddr,          32'h0);
    check("rst.arlen",  32'(axi_if.arlen),      32'd0);
    check("rst.arsize", 32'(axi_if.arsize),     32'd2);
    check("rst.arburst",32'(axi_if.arburst),    32'd1);
    check("rst.lock0",  32'(bus_lock_o),        32'd0);
    ifu_required = 1'b1;
    #1;
    check("rst.lock_req", 32'(bus_lock_o), 32'd1);
    ifu_required = 1'b0;
    rst = 1'b1;
    tick();

    // ---------------- single fetch ----------------
    ifu_araddr = 32'h3000_0004; ifu_arvalid = 1'b1; ifu_burst = 1'b0;
    axi_if.arready = 1'b1;
    tick();                                             // AR
    check("single.arvalid", 32'(axi_if.arvalid), 32'd1);
    check("single.araddr",  axi_if.araddr,       32'h3000_0004);
    check("single.arlen",   32'(axi_if.arlen),   32'd0);
    check("single.lock",    32'(bus_lock_o),     32'd1);
    check("single.rready_ar", 32'(axi_if.rready), 32'd0);
    tick();                                             // R
    check("single.arvalid_r", 32'(axi_if.arvalid), 32'd0);
    check("single.rready_r",  32'(axi_if.rready),  32'd1);
    check("single.no_early",  32'(ifu_rvalid),     32'd0);
    set_beat(1'b1, 32'h0000_0413, 2'b00, 1'b1);
    tick();                                             // RESP
    check("single.rvalid", 32'(ifu_rvalid),     32'd1);
    check("single.rdata",  ifu_rdata,           32'h0000_0413);
    check("single.rerr",   32'(ifu_rerr),       32'd0);
    check("single.rready_resp", 32'(axi_if.rready), 32'd0);
    ifu_arvalid = 1'b0;
    set_beat(1'b0, 32'h0, 2'b00, 1'b0);
    tick();                                             // IDLE
    check_quiet("single.idle");
    check("single.lock_idle", 32'(bus_lock_o), 32'd0);
    check("single.rdata_hold", ifu_rdata, 32'h0000_0413);

    // ---------------- burst fetch (IFU drops arvalid mid-way) ----------------
    ifu_araddr = 32'hA000_0000; ifu_arvalid = 1'b1; ifu_burst = 1'b1;
    tick();                                             // AR
    check("burst.arlen",   32'(axi_if.arlen),   32'd1);
    check("burst.arburst", 32'(axi_if.arburst), 32'd1);
    check("burst.araddr",  axi_if.araddr,       32'hA000_0000);
    ifu_arvalid = 1'b0;
    tick();                                             // R
    set_beat(1'b1, 32'h1111_1111, 2'b00, 1'b0);
    tick();                                             // RESP beat 0
    check("burst.b0.rvalid", 32'(ifu_rvalid),     32'd1);
    check("burst.b0.rdata",  ifu_rdata,           32'h1111_1111);
    check("burst.b0.rready", 32'(axi_if.rready),  32'd0);
    set_beat(1'b1, 32'h2222_2222, 2'b00, 1'b1);
    tick();                                             // R
    check("burst.gap.rvalid", 32'(ifu_rvalid),    32'd0);
    check("burst.gap.rready", 32'(axi_if.rready), 32'd1);
    tick();                                             // RESP beat 1
    check("burst.b1.rvalid", 32'(ifu_rvalid),     32'd1);
    check("burst.b1.rdata",  ifu_rdata,           32'h2222_2222);
    check("burst.b1.rready", 32'(axi_if.rready),  32'd0);
    set_beat(1'b0, 32'h0, 2'b00, 1'b0);
    tick();                                             // IDLE
    check_quiet("burst.idle");
    check("burst.lock_idle", 32'(bus_lock_o), 32'd0);

    // ---------------- misaligned burst -> single beat ----------------
    ifu_araddr = 32'hA000_0004; ifu_arvalid = 1'b1; ifu_burst = 1'b1;
    tick();                                             // AR
    check("mis.arlen",  32'(axi_if.arlen), 32'd0);
    check("mis.araddr", axi_if.araddr,     32'hA000_0004);
    tick();                                             // R
    set_beat(1'b1, 32'h3333_3333, 2'b00, 1'b1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ifu_rvalid) pulses++;
      if (ifu_rvalid) begin
        ifu_arvalid = 1'b0;
        set_beat(1'b0, 32'h0, 2'b00, 1'b0);
      end
    end
    check("mis.pulses", 32'(pulses), 32'd1);
    check_quiet("mis.idle");

    // ---------------- AR stall + back-to-back ----------------
    ifu_araddr = 32'h8000_0013; ifu_arvalid = 1'b1; ifu_burst = 1'b0;
    axi_if.arready = 1'b0;
    tick();                                             // AR, stalled
    ifu_araddr = 32'h1234_5678;                         // must be ignored
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall.arvalid%0d", i), 32'(axi_if.arvalid), 32'd1);
      check($sformatf("stall.araddr%0d", i),  axi_if.araddr,       32'h8000_0010);
      tick();
    end
    axi_if.arready = 1'b1;
    check("stall.still_ar", 32'(axi_if.rready), 32'd0);
    tick();                                             // R
    check("stall.rready", 32'(axi_if.rready), 32'd1);
    set_beat(1'b1, 32'h0000_0013, 2'b00, 1'b1);
    ifu_araddr = 32'h8000_0020;                         // next request, arvalid kept high
    tick();                                             // RESP
    check("b2b.rvalid",     32'(ifu_rvalid),      32'd1);
    check("b2b.no_ar_resp", 32'(axi_if.arvalid),  32'd0);
    set_beat(1'b0, 32'h0, 2'b00, 1'b0);
    tick();                                             // IDLE (accepts here)
    check("b2b.no_ar_idle", 32'(axi_if.arvalid),  32'd0);
    check("b2b.rvalid_off", 32'(ifu_rvalid),      32'd0);
    tick();                                             // AR for second request
    check("b2b.arvalid2", 32'(axi_if.arvalid), 32'd1);
    check("b2b.araddr2",  axi_if.araddr,       32'h8000_0020);
    tick();                                             // R
    set_beat(1'b1, 32'h0000_0020, 2'b00, 1'b1);
    tick();                                             // RESP
    check("b2b.rdata2", ifu_rdata, 32'h0000_0020);
    ifu_arvalid = 1'b0;
    set_beat(1'b0, 32'h0, 2'b00, 1'b0);
    tick();

    // ---------------- error response ----------------
    ifu_araddr = 32'h3000_0008; ifu_arvalid = 1'b1; ifu_burst = 1'b0;
    tick();                                             // AR
    tick();                                             // R
    set_beat(1'b1, 32'hDEAD_BEEF, 2'b10, 1'b1);
    tick();                                             // RESP
    check("err.rvalid", 32'(ifu_rvalid), 32'd1);
    check("err.rerr",   32'(ifu_rerr),   32'd1);
    check("err.rdata",  ifu_rdata,       32'hDEAD_BEEF);
    ifu_arvalid = 1'b0;
    set_beat(1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    check_quiet("err.idle");
    check("err.lock_idle", 32'(bus_lock_o), 32'd0);

    // ---------------- reset mid-burst ----------------
    ifu_araddr = 32'hA000_0000; ifu_arvalid = 1'b1; ifu_burst = 1'b1;
    tick();                                             // AR
    tick();                                             // R
    set_beat(1'b1, 32'h4444_4444, 2'b00, 1'b0);
    tick();                                             // RESP beat 0
    check("rstmid.b0", ifu_rdata, 32'h4444_4444);
    set_beat(1'b1, 32'h5555_5555, 2'b00, 1'b1);
    rst = 1'b0; ifu_required = 1'b1;
    tick();
    check_quiet("rstmid");
    check("rstmid.rdata",  ifu_rdata,         32'h0);
    check("rstmid.araddr", axi_if.araddr,     32'h0);
    check("rstmid.arlen",  32'(axi_if.arlen), 32'd0);
    check("rstmid.lock_req", 32'(bus_lock_o), 32'd1);
    ifu_required = 1'b0;
    #1;
    check("rstmid.lock0", 32'(bus_lock_o), 32'd0);
    rst = 1'b1; ifu_arvalid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ifu_rvalid) pulses++;
    end
    check("rstmid.no_pulse",  32'(pulses),        32'd0);
    check("rstmid.rready",    32'(axi_if.rready), 32'd0);
    check("rstmid.lock_idle", 32'(bus_lock_o),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
